// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store bus: word-organised RAM with a fixed
// request-to-done latency, sub-word access with sign/zero extension and error reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        st,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_f3;
  logic        r_ld;
  logic        r_err;

  logic [31:0] mem [DEPTH_WORDS];

  // Valid/ready contract: a request is taken when (ld|st) is high in IDLE; busy stays
  // high through WAIT and RESP and any request seen then is ignored; done marks completion.

  logic [31:0] c_addr;
  logic [2:0]  c_f3;
  logic        c_ld;
  logic        c_err;
  logic        enter_resp;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        unused_addr_bits;

  function automatic logic req_error(input logic l, input logic s, input logic [1:0] a,
                                     input logic [2:0] f);
    logic bad_f3;
    logic mis;
    bad_f3 = l ? !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : !(f inside {3'b000, 3'b001, 3'b010});
    mis    = ((f[1:0] == 2'b01) && a[0]) || ((f[1:0] == 2'b10) && (a != 2'b00));
    return (l && s) || bad_f3 || mis;
  endfunction

  // With LATENCY=1 the response cycle follows accept directly, so the load path
  // must look at the live inputs rather than the not-yet-loaded request registers.
  always_comb begin
    if (state == IDLE) begin
      c_addr = addr;
      c_f3   = funct3;
      c_ld   = ld;
      c_err  = req_error(ld, st, addr[1:0], funct3);
    end else begin
      c_addr = r_addr;
      c_f3   = r_f3;
      c_ld   = r_ld;
      c_err  = r_err;
    end
    enter_resp = ((state == IDLE) && (ld || st) && (LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == 4'd1));
  end

  assign unused_addr_bits = ^c_addr[31:AW+2];

  always_comb begin
    rd_word = mem[c_addr[AW+1:2]];
    rd_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
    rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (c_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_data = {24'b0, rd_byte};
      3'b101:  ld_data = {16'b0, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_f3   <= 3'd0;
      r_ld   <= 1'b0;
      r_err  <= 1'b0;
      o_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ld || st) begin
            r_addr <= addr;
            r_data <= i_data;
            r_f3   <= funct3;
            r_ld   <= ld;
            r_err  <= c_err;
            cnt    <= LAT_M1;
            state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp && c_ld && !c_err) o_data <= ld_data;
    end
  end

  always_comb begin
    be    = 4'b0000;
    wdata = r_data;
    case (r_f3[1:0])
      2'b00: begin
        be[r_addr[1:0]] = 1'b1;
        wdata           = {4{r_data[7:0]}};
      end
      2'b01: begin
        be    = r_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{r_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Stores commit on the edge that closes RESP; reset forces IDLE so nothing lands.
  always_ff @(posedge clk) begin
    if ((state == RESP) && !r_ld && !r_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[r_addr[AW+1:2]][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == RESP);
  assign err  = done && r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the core's load/store interface: accepts `ld`/`st` requests carrying `addr`, `i_data` and an RV32I size code, and returns `o_data` for loads.
- Internal word-organised RAM, fixed request-to-response latency, sub-word access with sign/zero extension, misalignment detection.
- Sits under `top`, on the opposite end of the core's `addr`/`i_data`/`o_data`/`ld`/`st` bus.
- Replaces the zero-wait behavioural memory so multi-cycle memory stalls are exercised in simulation and on the FPGA.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 2: cycles from request accept to `done`; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- ld  in  1  load request.
- st  in  1  store request.
- addr  in  32  byte address.
- funct3  in  3  RV32I size/sign code.
- i_data  in  32  store data (core to memory), right-aligned.
- o_data  out  32  load result, extended to 32 bits.
- busy  out  1  request in flight; new requests are ignored while high.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with `done`; misaligned, illegal funct3, or `ld` and `st` both high.

Behaviour:
- Reset values (asynchronous): o_data=0, busy=0, done=0, err=0, state=IDLE, latency counter=0. RAM contents are not cleared.
- States:
  - IDLE: accept when (ld|st)=1. On the accept edge, capture addr, funct3, i_data, kind=ld/st into request registers; counter=LATENCY-1; go to WAIT, or to RESP if LATENCY=1. Inputs may change after accept.
  - WAIT: counter decrements each cycle; at 0 go to RESP.
  - RESP: done=1 for exactly one cycle, then back to IDLE.
- busy is high in WAIT and RESP.
- Request at T gives done at T+LATENCY. The earliest next accept is T+LATENCY+1, because requests presented in RESP are ignored. The core holds `ld`/`st` until it sees `done`.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses alias modulo DEPTH_WORDS*4 bytes.
- Legal load funct3:
  - 000 lb: sign-extended byte at addr[1:0].
  - 001 lh: sign-extended half at addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extended byte.
  - 101 lhu: zero-extended half.
- Legal store funct3:
  - 000 sb: writes only the addressed byte lane with i_data[7:0].
  - 001 sh: writes only the addressed half with i_data[15:0].
  - 010 sw: writes the full word.
- Byte order is little-endian: byte lane k is word bits [8k+7:8k].
- Error cases give err=1 with done, no RAM write, and o_data unchanged:
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
  - Any funct3 not listed above.
  - ld=1 and st=1 together at accept.
  - The request still takes the full LATENCY.
- Store: the RAM write commits on the clock edge that ends the RESP cycle. Store completions do not change o_data.
- Load: RAM is read in RESP. o_data is updated at the start of the RESP cycle (valid while done=1) and held until the next successful load.
- Reset mid-operation: the request is abandoned, no write is committed, and all outputs return to reset values immediately.

Test Plan:
- sw addr=0x10, i_data=0xDEADBEEF, then lw 0x10 with LATENCY=2 -> each done exactly 2 cycles after accept; o_data=0xDEADBEEF; busy high for 2 cycles per request.
- After the word above: sb addr=0x11 i_data=0x000000A5; lb 0x11 -> 0xFFFFFFA5; lbu 0x11 -> 0x000000A5; lw 0x10 -> 0xDEADA5EF.
- sh addr=0x22 i_data=0x8001, then lh 0x22 -> 0xFFFF8001 and lhu 0x22 -> 0x00008001; lw 0x20 -> upper half 0x8001, lower half unchanged from prior contents.
- lw 0x13, sh 0x21, funct3=011 load, and ld=st=1 each -> done with err=1; following lw 0x10 shows no corruption; o_data unchanged after the error cycles.
- Request held across its own done plus a new request presented during RESP -> only one accept per LATENCY+1 window; aliasing check: sw 0x0 then lw (DEPTH_WORDS*4) -> same data.
- sw 0x30 = 0x12345678 pending, assert rst one cycle before done -> done never pulses, outputs 0; subsequent lw 0x30 returns the old contents, not 0x12345678.
